// File: rtl/rom_reader_pkg.sv
// rom_reader_pkg: shared types and default widths for the boot-ROM burst reader.
//   state_t      : engine state (IDLE, READ)
//   RR_*         : default ROM address / data / burst-length widths
//   skid_entry_t : one buffered response beat {data, last, err}
package rom_reader_pkg;

   localparam int RR_ADDR_W = 12;
   localparam int RR_DATA_W = 32;
   localparam int RR_LEN_W  = 4;

   typedef enum logic {IDLE, READ} state_t;

   typedef struct packed {
      logic [RR_DATA_W-1:0] data;
      logic                 last;
      logic                 err;
   } skid_entry_t;

endpackage

// File: rtl/rom_rsp_skid.sv
// rom_rsp_skid: 2-entry response FIFO sitting between the ROM capture point and
// the response stream. Its occupancy feeds the fetch-credit check in the top.
//   clk, rst_n       : clock, async active-low reset
//   i_push, i_data   : write one captured beat (caller guarantees space)
//   o_valid, i_ready : head beat valid / consumer accept
//   o_data           : head beat
//   o_occ            : number of buffered beats (0..2)
module rom_rsp_skid
   import rom_reader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_push,
   input  skid_entry_t i_data,
   output logic        o_valid,
   input  logic        i_ready,
   output skid_entry_t o_data,
   output logic [1:0]  o_occ
);

   skid_entry_t r_mem [2];
   logic        r_wp;
   logic        r_rp;
   logic [1:0]  r_cnt;
   logic        w_pop;

   assign o_valid = (r_cnt != 2'd0);
   assign o_data  = r_mem[r_rp];
   assign o_occ   = r_cnt;
   assign w_pop   = o_valid && i_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wp     <= 1'b0;
         r_rp     <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wp] <= i_data;
            r_wp        <= ~r_wp;
         end
         if (w_pop)
            r_rp <= ~r_rp;
         case ({i_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/rom_reader.sv
// rom_reader: burst read engine in front of the boot ROM macro. Takes a
// word-addressed burst request, drives rom_cs/rom_oe/rom_a, captures rom_do one
// cycle after each fetch and returns the words on a valid/ready stream.
//   ACLK, ARESETn           : clock, async active-low reset
//   req_valid/ready/addr/len: burst request (len = beats-1)
//   rsp_valid/ready/data/last/err : response beats
//   rom_cs, rom_oe, rom_a, rom_do : ROM pins
// Optional feature macro ROM_BOUND_CHECK_EN: beats past the ROM top are not
// fetched and come back as data 0 with rsp_err=1. Without it addresses wrap.
module rom_reader
   import rom_reader_pkg::*;
#(
   parameter int ADDR_W = RR_ADDR_W,
   parameter int DATA_W = RR_DATA_W,
   parameter int LEN_W  = RR_LEN_W
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   output logic              rsp_err,
   output logic              rom_cs,
   output logic              rom_oe,
   output logic [ADDR_W-1:0] rom_a,
   input  logic [DATA_W-1:0] rom_do
);

   // One extra address bit marks beats that ran past the ROM top.
`ifdef ROM_BOUND_CHECK_EN
   localparam int AW = ADDR_W + 1;
`else
   localparam int AW = ADDR_W;
`endif

   state_t          r_state;
   logic [AW-1:0]   r_addr;
   logic [LEN_W:0]  r_issue_rem;    // beats still to issue
   logic [LEN_W-1:0] r_ret_cnt;     // beats still to capture, minus one
   logic            r_inflight;     // fetch slot issued last cycle
   logic            r_inflight_oob; // that slot was out of bounds

   logic            w_oob;
   logic            w_issue;
   logic            w_pop;
   logic [2:0]      w_used;
   logic [1:0]      w_occ;
   logic            w_valid;
   skid_entry_t     w_push;
   skid_entry_t     w_head;

`ifdef ROM_BOUND_CHECK_EN
   assign w_oob = r_addr[ADDR_W];
`else
   assign w_oob = 1'b0;
`endif

   assign w_pop  = w_valid && rsp_ready;
   assign w_used = {2'b00, r_inflight} + {1'b0, w_occ};

   // Credit check: in-flight + buffered must stay within the 2 buffer slots.
   // A pop in this cycle frees a slot, so issue resumes without a bubble.
   assign w_issue = (r_state == READ) && (r_issue_rem != '0) &&
                    ((w_used < 3'd2) || ((w_used == 3'd2) && w_pop));

   assign req_ready = (r_state == IDLE);
   assign rom_oe    = (r_state == READ);
   assign rom_cs    = w_issue && !w_oob;
   assign rom_a     = r_addr[ADDR_W-1:0];

   always_comb begin
      w_push      = '0;
      w_push.data = r_inflight_oob ? '0 : rom_do;
      w_push.last = (r_ret_cnt == '0);
      w_push.err  = r_inflight_oob;
   end

   rom_rsp_skid u_skid (
      .clk     (ACLK),
      .rst_n   (ARESETn),
      .i_push  (r_inflight),
      .i_data  (w_push),
      .o_valid (w_valid),
      .i_ready (rsp_ready),
      .o_data  (w_head),
      .o_occ   (w_occ)
   );

   assign rsp_valid = w_valid;
   assign rsp_data  = w_head.data;
   assign rsp_last  = w_valid && w_head.last;
   assign rsp_err   = w_valid && w_head.err;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state        <= IDLE;
         r_addr         <= '0;
         r_issue_rem    <= '0;
         r_ret_cnt      <= '0;
         r_inflight     <= 1'b0;
         r_inflight_oob <= 1'b0;
      end else begin
         r_inflight     <= w_issue;
         r_inflight_oob <= w_issue && w_oob;
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_state     <= READ;
                  r_addr      <= AW'(req_addr);
                  r_issue_rem <= {1'b0, req_len} + {{LEN_W{1'b0}}, 1'b1};
                  r_ret_cnt   <= req_len;
               end
            end
            READ: begin
               if (w_issue) begin
                  r_addr      <= r_addr + AW'(1);
                  r_issue_rem <= r_issue_rem - {{LEN_W{1'b0}}, 1'b1};
               end
               if (r_inflight)
                  r_ret_cnt <= r_ret_cnt - {{(LEN_W-1){1'b0}}, 1'b1};
               if (w_pop && w_head.last)
                  r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_reader.sv
// tb_rom_reader: directed table-driven bench for rom_reader. The ROM model holds
// word i at address i, except address 0x010 which holds 0xDEADBEEF.
module tb_rom_reader;

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [11:0] req_addr = '0;
   logic [3:0]  req_len = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        rsp_last;
   logic        rsp_err;
   logic        rom_cs;
   logic        rom_oe;
   logic [11:0] rom_a;
   logic [31:0] rom_do;
   logic [31:0] rom_q = '0;

   int total = 0;
   int bad   = 0;

   rom_reader dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_last(rsp_last), .rsp_err(rsp_err),
      .rom_cs(rom_cs), .rom_oe(rom_oe), .rom_a(rom_a), .rom_do(rom_do)
   );

   always #5 ACLK = ~ACLK;

   function automatic logic [31:0] rom_word(input logic [11:0] a);
      return (a == 12'h010) ? 32'hDEADBEEF : {20'h0, a};
   endfunction

   // Registered-output ROM macro model.
   always @(posedge ACLK) if (rom_cs) rom_q <= rom_word(rom_a);
   assign rom_do = rom_oe ? rom_q : 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic rdy(input int mode, input int cyc);
      logic [3:0] pat;
      pat = 4'b1001;  // 1,0,0,1 read from bit 3 down
      case (mode)
         0:       return 1'b1;
         1:       return pat[3 - (cyc % 4)];
         default: return (cyc >= 6);
      endcase
   endfunction

   typedef struct {
      logic [11:0] addr;
      logic [3:0]  len;
      int          mode;
      int          exp_cs;
   } vec_t;

   task automatic run_burst(input vec_t v, input bit hold);
      int cyc = 0, beats = 0, cs = 0, first = -1, maxpend = 0, holdbad = 0;
      bit prev_stall = 0;
      logic [31:0] pdata = '0;
      logic plast = 0, perr = 0;
      logic [12:0] ae;
      bit oob;
      @(negedge ACLK);
      req_valid = 1'b1; req_addr = v.addr; req_len = v.len; rsp_ready = 1'b0;
      #1 chk("req_ready_idle", req_ready, 1);
      @(posedge ACLK);
      while (beats < int'(v.len) + 1 && cyc < 300) begin
         @(negedge ACLK);
         if (!hold) req_valid = 1'b0;
         rsp_ready = rdy(v.mode, cyc);
         #1;
         if (rom_cs) cs++;
         if (cyc == 0) begin
            chk("first_cs", rom_cs, 1);
            chk("oe_read", rom_oe, 1);
         end
         if (hold && req_ready) holdbad++;
         if (rsp_valid && first < 0) first = cyc;
         if (rsp_valid) begin
            if (prev_stall) begin
               chk("stall_stable", {rsp_data ^ pdata, 30'd0, rsp_last ^ plast, rsp_err ^ perr} == '0, 1);
            end
            if (rsp_ready) begin
               ae  = {1'b0, v.addr} + 13'(beats);
`ifdef ROM_BOUND_CHECK_EN
               oob = ae[12];
`else
               oob = 1'b0;
`endif
               chk("beat_data", rsp_data, oob ? 32'h0 : rom_word(ae[11:0]));
               chk("beat_last", rsp_last, beats == int'(v.len));
               chk("beat_err",  rsp_err, oob);
               if (v.mode == 0) chk("beat_cyc", cyc, 2 + beats);
               beats++;
            end
            prev_stall = !rsp_ready;
            pdata = rsp_data; plast = rsp_last; perr = rsp_err;
         end else prev_stall = 0;
         if (cs - beats > maxpend) maxpend = cs - beats;
         cyc++;
      end
      chk("burst_timeout", cyc < 300, 1);
      chk("first_latency", first, 2);
      chk("cs_count", cs, v.exp_cs);
      chk("max_pending", maxpend <= 2, 1);
      if (hold) chk("held_off", holdbad, 0);
      @(posedge ACLK);
      #1;
      chk("idle_ready", req_ready, 1);
      chk("idle_valid", rsp_valid, 0);
      chk("idle_oe", rom_oe, 0);
   endtask

   vec_t vecs [5];
   vec_t va, vb;
   int   n, flag;

   initial begin
      vecs[0] = '{addr: 12'h010, len: 4'd0,  mode: 0, exp_cs: 1};
      vecs[1] = '{addr: 12'h100, len: 4'd15, mode: 0, exp_cs: 16};
      vecs[2] = '{addr: 12'h100, len: 4'd15, mode: 1, exp_cs: 16};
`ifdef ROM_BOUND_CHECK_EN
      vecs[3] = '{addr: 12'hFFE, len: 4'd3,  mode: 0, exp_cs: 2};
`else
      vecs[3] = '{addr: 12'hFFE, len: 4'd3,  mode: 0, exp_cs: 4};
`endif
      vecs[4] = '{addr: 12'h7F0, len: 4'd7,  mode: 2, exp_cs: 8};

      // Reset values
      #2 ARESETn = 1'b0;
      #1;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_last", rsp_last, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rom_cs", rom_cs, 0);
      chk("rst_rom_oe", rom_oe, 0);
      chk("rst_rom_a", rom_a, 0);
      repeat (3) @(negedge ACLK);
      ARESETn = 1'b1;

      for (int i = 0; i < 5; i++) run_burst(vecs[i], 1'b0);

      // req_valid held through READ: next request taken one edge after last beat.
      va = '{addr: 12'h300, len: 4'd3, mode: 0, exp_cs: 4};
      vb = '{addr: 12'h020, len: 4'd1, mode: 0, exp_cs: 2};
      run_burst(va, 1'b1);
      run_burst(vb, 1'b0);

      // Reset mid-burst after beat 5 of 8.
      @(negedge ACLK);
      req_valid = 1'b1; req_addr = 12'h200; req_len = 4'd7;
      @(posedge ACLK);
      n = 0;
      for (int c = 0; c < 7; c++) begin
         @(negedge ACLK);
         req_valid = 1'b0; rsp_ready = 1'b1;
         #1 if (rsp_valid && rsp_ready) n++;
      end
      chk("rst_pre_beats", n, 5);
      @(negedge ACLK);
      ARESETn = 1'b0;
      #1;
      chk("mid_rst_valid", rsp_valid, 0);
      chk("mid_rst_data", rsp_data, 0);
      chk("mid_rst_last", rsp_last, 0);
      chk("mid_rst_cs", rom_cs, 0);
      chk("mid_rst_oe", rom_oe, 0);
      chk("mid_rst_a", rom_a, 0);
      chk("mid_rst_ready", req_ready, 1);
      repeat (2) @(negedge ACLK);
      ARESETn = 1'b1;
      flag = 0;
      repeat (6) begin
         @(negedge ACLK);
         #1 if (rsp_valid || rom_cs || rom_oe) flag++;
      end
      chk("post_rst_quiet", flag, 0);
      run_burst(vecs[0], 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
